sort_bitonic_pipe: RTL and testbench
====================================

// Module: sort_bitonic_pipe
// PURPOSE
// - Clocked, pipelined bitonic sorting network for N = 2**LOG_N elements of WIDTH bits.
// - Accepts one packed vector per cycle and returns it fully sorted STAGES cycles later.
// - Sort direction is selectable per vector.
// - Serves as the synchronous, parametrised sorter for datapaths that cannot use the
//   req/fin self-timed 8-input sorter.
// PARAMETERS
// - WIDTH   16  bits per element
// - LOG_N   3   log2 of element count; N = 2**LOG_N; legal range 1..5
// - SIGNED  0   1: compare as two's complement; 0: compare as unsigned
// PORTS
// - clk        in   1          rising-edge clock
// - rst_n      in   1          asynchronous active-low reset
// - in_valid   in   1          in_data/in_desc valid
// - in_ready   out  1          block can accept a vector this cycle
// - in_data    in   WIDTH*N    element i at [i*WIDTH +: WIDTH]
// - in_desc    in   1          1: descending sort, 0: ascending sort
// - out_valid  out  1          out_data valid
// - out_ready  in   1          consumer accepts out_data this cycle
// - out_data   out  WIDTH*N    sorted; element 0 is the minimum (asc) or maximum (desc)
// - out_desc   out  1          in_desc value carried with the vector
// - busy       out  1          OR of all stage valid bits
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-low.
// - Network: standard bitonic sort. STAGES = LOG_N*(LOG_N+1)/2 compare-exchange layers,
//   one register rank after each layer (N=8: 6 ranks).
// - Compare-exchange: swap only when lo > hi in the effective direction.
//   Equal keys never swap.
// - Effective direction per pair = bitonic direction XOR the stage's desc bit.
// - Each rank holds data[N*WIDTH], desc, and valid. The desc bit travels with its vector.
// - Global stall: adv = !out_valid | out_ready; in_ready = adv (combinational).
// - When adv = 1, all ranks shift.
//   - Rank0 loads the network of in_data; valid0 <= in_valid.
//   - Bubbles advance as invalid slots and are not collapsed.
// - When adv = 0, every rank holds; in_data is ignored.
// - Latency: a vector accepted in cycle t appears with out_valid=1 in cycle t+STAGES,
//   with no stalls.
// - Throughput: 1 vector/cycle.
// - out_data/out_desc remain stable while out_valid=1 and out_ready=0 (AXI-style).
// - Transfer occurs on in_valid&in_ready (input side) and out_valid&out_ready (output side).
// - Reset values: all valid bits 0, all data registers 0, out_desc 0, busy 0.
//   in_ready is therefore 1 after reset.
// - Reset mid-operation: in-flight vectors are discarded with no partial output.
//   The first accept after deassertion behaves as from cold.
// - Simultaneous output accept and input accept in a full pipe is legal.
//   The pipe stays full with no gap.
// - LOG_N=1 degenerates to a single compare-exchange (STAGES=1).
// - SIGNED=1: 16'h8000 sorts below 16'h7FFF. SIGNED=0: the reverse.
// - Element values are never modified, only permuted.
//   The output is a permutation of the input.
// CONFIGURATION
// - Macro SORT_INDEX_EN.
// - Defined:
//   - Each element carries a LOG_N-bit tag equal to its input position.
//   - Compare key = {value, tag} (tag is the LSBs, always ascending), so equal values keep
//     input order (stable sort).
//   - Adds port out_index (out, LOG_N*N): tag of output element i at [i*LOG_N +: LOG_N].
//   - Tags reset to 0.
// - Undefined: no tags, no out_index port. Equal values are indistinguishable and the
//   ordering among them is unspecified.
// TESTING
// 1. WIDTH=16, LOG_N=3, asc: in {7,3,9,1,8,2,6,5} (element 0 first)
//    -> after 6 cycles out {1,2,3,5,6,7,8,9}, out_valid=1 for 1 cycle.
// 2. Same data, in_desc=1 -> out {9,8,7,6,5,3,2,1}, out_desc=1.
// 3. Back-to-back stream: 20 random vectors, in_valid=1, out_ready=1
//    -> 20 consecutive out_valid cycles, each sorted, in order.
// 4. Backpressure: hold out_ready=0 for 10 cycles with a full pipe -> in_ready=0.
//    out_data stays frozen and no vector is lost or duplicated. Release -> remaining 6
//    drain in order.
// 5. SIGNED=1, in {16'h8000,16'h7FFF,0,16'hFFFF,...} -> 16'h8000 first, 16'hFFFF
//    before 0, 16'h7FFF last (asc).
// 6. Assert rst_n=0 for 1 cycle with 3 vectors in flight -> out_valid=0, busy=0 at once.
//    The next vector emerges after exactly 6 cycles. With SORT_INDEX_EN and input
//    {4,4,4,4,4,4,4,4}, out_index = {0,1,2,3,4,5,6,7}.

Source files
------------

// File: rtl/sort_bitonic_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sort_bitonic_pipe                                            |
// | Description : Pipelined bitonic sorting network. Sorts N = 2**LOG_N        |
// |               elements of WIDTH bits, one vector per cycle, with one       |
// |               register rank after every compare-exchange layer             |
// |               (STAGES = LOG_N*(LOG_N+1)/2). Sort direction travels with    |
// |               each vector. A single global stall freezes every rank while  |
// |               the output is valid and not accepted.                        |
// | Ports       : clk, rst_n (async, active-low)                               |
// |               in_valid/in_ready/in_data/in_desc   - input handshake        |
// |               out_valid/out_ready/out_data/out_desc - output handshake     |
// |               busy      - any rank holds a valid vector                    |
// |               out_index - input position of each output element           |
// |                           (only with SORT_INDEX_EN)                        |
// | Macro       : SORT_INDEX_EN - tag elements with their input position and   |
// |               use the tag as a tie-break, giving a stable sort.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sort_bitonic_pipe #(
  parameter int WIDTH  = 16,
  parameter int LOG_N  = 3,
  parameter int SIGNED = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH*(2**LOG_N)-1:0]   in_data,
  input  logic                          in_desc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH*(2**LOG_N)-1:0]   out_data,
  output logic                          out_desc,
  output logic                          busy
`ifdef SORT_INDEX_EN
  ,
  output logic [LOG_N*(2**LOG_N)-1:0]   out_index
`endif
);

  localparam int N      = 2 ** LOG_N;
  localparam int STAGES = LOG_N * (LOG_N + 1) / 2;
`ifdef SORT_INDEX_EN
  localparam int TW     = LOG_N;
`else
  localparam int TW     = 0;
`endif
  // Element storage: value in the upper WIDTH bits, tag (if any) below it.
  localparam int EW     = WIDTH + TW;

  // Layer l of the network belongs to merge phase P (block size 2**(P+1))
  // and uses exchange distance 2**Q.
  function automatic int layer_p(input int l);
    int c, r;
    c = 0;
    r = 0;
    for (int p = 0; p < LOG_N; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (c == l) r = p;
        c = c + 1;
      end
    end
    return r;
  endfunction

  function automatic int layer_q(input int l);
    int c, r;
    c = 0;
    r = 0;
    for (int p = 0; p < LOG_N; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (c == l) r = q;
        c = c + 1;
      end
    end
    return r;
  endfunction

  // True when element a must come after element b in the final order for
  // this vector's direction. Signed values are compared unsigned after an
  // MSB flip. With tags, equal values fall back to ascending tag order in
  // both directions, which is what makes the sort stable.
  function automatic logic after_key(input logic [EW-1:0] a,
                                     input logic [EW-1:0] b,
                                     input logic          desc);
    logic [WIDTH-1:0] va, vb;
    logic             res;
    va = a[EW-1 -: WIDTH];
    vb = b[EW-1 -: WIDTH];
    if (SIGNED != 0) begin
      va[WIDTH-1] = ~va[WIDTH-1];
      vb[WIDTH-1] = ~vb[WIDTH-1];
    end
    res = desc ? (va < vb) : (va > vb);
`ifdef SORT_INDEX_EN
    if (va == vb) res = (a[TW-1:0] > b[TW-1:0]);
`endif
    return res;
  endfunction

  // One compare-exchange layer. Blocks whose bit (P+1) of the index is set
  // run in the opposite bitonic direction, so their swap test is reversed.
  function automatic logic [N*EW-1:0] cx_layer(input logic [N*EW-1:0] d,
                                               input logic            desc,
                                               input int              p,
                                               input int              q);
    logic [N*EW-1:0] r;
    logic [EW-1:0]   a, b;
    logic            swap;
    int              j;
    r = d;
    for (int i = 0; i < N; i++) begin
      j = i ^ (1 << q);
      if (j > i) begin
        a = d[i*EW +: EW];
        b = d[j*EW +: EW];
        if (((i >> (p + 1)) & 1) != 0) swap = after_key(b, a, desc);
        else                           swap = after_key(a, b, desc);
        if (swap) begin
          r[i*EW +: EW] = b;
          r[j*EW +: EW] = a;
        end
      end
    end
    return r;
  endfunction

  logic [N*EW-1:0] r_data  [STAGES];
  logic            r_desc  [STAGES];
  logic            r_valid [STAGES];
  logic [N*EW-1:0] w_next  [STAGES];
  logic [N*EW-1:0] w_in;
  logic            w_adv;

  assign out_valid = r_valid[STAGES-1];
  assign w_adv     = ~out_valid | out_ready;
  assign in_ready  = w_adv;
  assign out_desc  = r_desc[STAGES-1];

  always_comb begin
    w_in = '0;
    for (int i = 0; i < N; i++) begin
      w_in[i*EW+TW +: WIDTH] = in_data[i*WIDTH +: WIDTH];
`ifdef SORT_INDEX_EN
      w_in[i*EW +: TW] = LOG_N'(i);
`endif
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_layer
    localparam int P = layer_p(s);
    localparam int Q = layer_q(s);
    if (s == 0) begin : g_first
      assign w_next[s] = cx_layer(w_in, in_desc, P, Q);
    end else begin : g_rest
      assign w_next[s] = cx_layer(r_data[s-1], r_desc[s-1], P, Q);
    end
  end

  // All ranks move together; bubbles shift through as invalid slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        r_data[s]  <= '0;
        r_desc[s]  <= 1'b0;
        r_valid[s] <= 1'b0;
      end
    end else if (w_adv) begin
      r_data[0]  <= w_next[0];
      r_desc[0]  <= in_desc;
      r_valid[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        r_data[s]  <= w_next[s];
        r_desc[s]  <= r_desc[s-1];
        r_valid[s] <= r_valid[s-1];
      end
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int s = 0; s < STAGES; s++) busy = busy | r_valid[s];
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < N; i++) out_data[i*WIDTH +: WIDTH] = r_data[STAGES-1][i*EW+TW +: WIDTH];
  end

`ifdef SORT_INDEX_EN
  always_comb begin
    out_index = '0;
    for (int i = 0; i < N; i++) out_index[i*LOG_N +: LOG_N] = r_data[STAGES-1][i*EW +: TW];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sort_bitonic_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sort_bitonic_pipe                                         |
// | Description : Directed self-checking bench for sort_bitonic_pipe. Three    |
// |               instances: unsigned 8x16, signed 8x16, and unsigned 2x8      |
// |               (LOG_N=1). Honours SORT_INDEX_EN for out_index checks.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_sort_bitonic_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  int           tests = 0;
  int           fails = 0;

  // Unsigned 8 x 16
  logic         in_valid, in_ready, in_desc, out_valid, out_ready, out_desc, busy;
  logic [127:0] in_data, out_data;
  // Signed 8 x 16
  logic         s_in_valid, s_in_ready, s_in_desc, s_out_valid, s_out_ready, s_out_desc, s_busy;
  logic [127:0] s_in_data, s_out_data;
  // Unsigned 2 x 8
  logic         t_in_valid, t_in_ready, t_in_desc, t_out_valid, t_out_ready, t_out_desc, t_busy;
  logic [15:0]  t_in_data, t_out_data;
`ifdef SORT_INDEX_EN
  logic [23:0]  out_index, s_out_index;
  logic [1:0]   t_out_index;
`endif

  always #5 clk = ~clk;

  sort_bitonic_pipe #(.WIDTH(16), .LOG_N(3), .SIGNED(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_desc(out_desc), .busy(busy)
`ifdef SORT_INDEX_EN
    , .out_index(out_index)
`endif
  );

  sort_bitonic_pipe #(.WIDTH(16), .LOG_N(3), .SIGNED(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_desc(s_in_desc), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .out_desc(s_out_desc), .busy(s_busy)
`ifdef SORT_INDEX_EN
    , .out_index(s_out_index)
`endif
  );

  sort_bitonic_pipe #(.WIDTH(8), .LOG_N(1), .SIGNED(0)) dut_t (
    .clk(clk), .rst_n(rst_n), .in_valid(t_in_valid), .in_ready(t_in_ready), .in_data(t_in_data),
    .in_desc(t_in_desc), .out_valid(t_out_valid), .out_ready(t_out_ready), .out_data(t_out_data),
    .out_desc(t_out_desc), .busy(t_busy)
`ifdef SORT_INDEX_EN
    , .out_index(t_out_index)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pk8(input logic [15:0] a [8]);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = a[i];
    return r;
  endfunction

  function automatic logic [127:0] rand_vec();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'($urandom);
    return r;
  endfunction

  // Reference model: plain bubble sort, unsigned compare.
  function automatic logic [127:0] sort_ref(input logic [127:0] v, input logic desc);
    logic [15:0] e [8];
    logic [15:0] t;
    for (int i = 0; i < 8; i++) e[i] = v[i*16 +: 16];
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (desc ? (e[j] < e[j+1]) : (e[j] > e[j+1])) begin
          t = e[j]; e[j] = e[j+1]; e[j+1] = t;
        end
    return pk8(e);
  endfunction

  // Pushes one vector into the unsigned 8x16 instance and watches 20 cycles.
  task automatic run_one(input logic [127:0] d, input logic desc,
                         output logic [127:0] od, output logic odesc,
                         output int lat, output logic extra
`ifdef SORT_INDEX_EN
                         , output logic [23:0] oi
`endif
                         );
    in_data = d; in_desc = desc; in_valid = 1'b1; out_ready = 1'b1;
    lat = -1; extra = 1'b0; od = '0; odesc = 1'b0;
`ifdef SORT_INDEX_EN
    oi = '0;
`endif
    for (int k = 1; k <= 20; k++) begin
      tick();
      in_valid = 1'b0;
      if (out_valid) begin
        if (lat < 0) begin
          lat = k; od = out_data; odesc = out_desc;
`ifdef SORT_INDEX_EN
          oi = out_index;
`endif
        end else extra = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 0; in_desc = 0; in_data = '0; out_ready = 1;
    s_in_valid = 0; s_in_desc = 0; s_in_data = '0; s_out_ready = 1;
    t_in_valid = 0; t_in_desc = 0; t_in_data = '0; t_out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++; if (out_data !== 128'd0) begin fails++; $display("FAIL reset_out_data got %h want 0", out_data); end
    tests++; if (out_desc !== 1'b0) begin fails++; $display("FAIL reset_out_desc got %b want 0", out_desc); end
  endtask

  task automatic test_asc_desc();
    logic [15:0]  a [8];
    logic [127:0] od, exp_a, exp_d;
    logic         odesc, extra;
    int           lat;
`ifdef SORT_INDEX_EN
    logic [23:0]  oi;
`endif
    a = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd5};
    exp_a = pk8('{16'd1, 16'd2, 16'd3, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9});
    exp_d = pk8('{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd3, 16'd2, 16'd1});
    for (int dir = 0; dir < 2; dir++) begin
      run_one(pk8(a), dir[0], od, odesc, lat, extra
`ifdef SORT_INDEX_EN
              , oi
`endif
              );
      tests++; if (lat !== 6) begin fails++; $display("FAIL dir%0d_latency got %0d want 6", dir, lat); end
      tests++; if (od !== (dir == 0 ? exp_a : exp_d)) begin fails++; $display("FAIL dir%0d_data got %h want %h", dir, od, (dir == 0 ? exp_a : exp_d)); end
      tests++; if (odesc !== dir[0]) begin fails++; $display("FAIL dir%0d_out_desc got %b want %b", dir, odesc, dir[0]); end
      tests++; if (extra !== 1'b0) begin fails++; $display("FAIL dir%0d_single_valid got %b want 0", dir, extra); end
`ifdef SORT_INDEX_EN
      // 7,3,9,1,8,2,6,5 -> positions of 1,2,3,5,6,7,8,9 are 3,5,1,7,6,0,4,2
      tests++;
      if (oi !== (dir == 0 ? {3'd2,3'd4,3'd0,3'd6,3'd7,3'd1,3'd5,3'd3}
                           : {3'd3,3'd5,3'd1,3'd7,3'd6,3'd0,3'd4,3'd2})) begin
        fails++; $display("FAIL dir%0d_index got %h", dir, oi);
      end
`endif
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] exp_q [$];
    logic         exp_d [$];
    logic [127:0] v;
    logic         dd;
    int           got, first, last;
    got = 0; first = -1; last = -1; out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (out_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL b2b_unexpected got %h want none", out_data);
        end else begin
          if (out_data !== exp_q[0] || out_desc !== exp_d[0]) begin
            fails++; $display("FAIL b2b_vec%0d got %h/%b want %h/%b", got, out_data, out_desc, exp_q[0], exp_d[0]);
          end
          void'(exp_q.pop_front());
          void'(exp_d.pop_front());
        end
        got++;
        if (first < 0) first = c;
        last = c;
      end
      if (c < 20) begin
        v = rand_vec();
        dd = 1'($urandom_range(0, 1));
        in_valid = 1'b1; in_data = v; in_desc = dd;
        exp_q.push_back(sort_ref(v, dd));
        exp_d.push_back(dd);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_in_ready got %b want 1", in_ready); end
      end else in_valid = 1'b0;
      tick();
    end
    tests++; if (got !== 20) begin fails++; $display("FAIL b2b_count got %0d want 20", got); end
    tests++; if (last - first !== 19) begin fails++; $display("FAIL b2b_gapless got span %0d want 19", last - first); end
  endtask

  task automatic test_backpressure();
    logic [127:0] bv [7];
    int           idx;
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bv[k] = rand_vec();
      in_valid = 1'b1; in_data = bv[k]; in_desc = 1'b0;
      tick();
    end
    bv[6] = rand_vec();
    in_data = bv[6];   // offered while stalled; must never be taken
    for (int h = 0; h < 10; h++) begin
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_out_valid cyc%0d got %b want 1", h, out_valid); end
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc%0d got %b want 0", h, in_ready); end
      tests++; if (out_data !== sort_ref(bv[0], 1'b0)) begin fails++; $display("FAIL bp_frozen cyc%0d got %h want %h", h, out_data, sort_ref(bv[0], 1'b0)); end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        tests++;
        if (idx >= 6) begin
          fails++; $display("FAIL bp_extra got %h want none", out_data);
        end else if (out_data !== sort_ref(bv[idx], 1'b0)) begin
          fails++; $display("FAIL bp_drain%0d got %h want %h", idx, out_data, sort_ref(bv[idx], 1'b0));
        end
        idx++;
      end
      tick();
    end
    tests++; if (idx !== 6) begin fails++; $display("FAIL bp_drain_count got %0d want 6", idx); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bp_busy_after got %b want 0", busy); end
  endtask

  task automatic test_signed();
    logic [127:0] vin, od, exp_s [2];
    logic         odesc, extra;
    int           lat;
`ifdef SORT_INDEX_EN
    logic [23:0]  oi;
`endif
    vin = pk8('{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001, 16'h8001, 16'h7FFE, 16'hFFFE});
    exp_s[0] = pk8('{16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h7FFE, 16'h7FFF});
    exp_s[1] = pk8('{16'h7FFF, 16'h7FFE, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE, 16'h8001, 16'h8000});
    tests++; if (s_in_ready !== 1'b1) begin fails++; $display("FAIL signed_in_ready got %b want 1", s_in_ready); end
    for (int dir = 0; dir < 2; dir++) begin
      s_in_data = vin; s_in_desc = dir[0]; s_in_valid = 1'b1; lat = -1; od = '0; odesc = 1'b0;
      for (int k = 1; k <= 20; k++) begin
        tick();
        s_in_valid = 1'b0;
        if (s_out_valid && lat < 0) begin lat = k; od = s_out_data; odesc = s_out_desc; end
      end
      tests++; if (lat !== 6) begin fails++; $display("FAIL signed%0d_latency got %0d want 6", dir, lat); end
      tests++; if (od !== exp_s[dir]) begin fails++; $display("FAIL signed%0d_data got %h want %h", dir, od, exp_s[dir]); end
      tests++; if (odesc !== dir[0]) begin fails++; $display("FAIL signed%0d_desc got %b want %b", dir, odesc, dir[0]); end
    end
    // Same vector through the unsigned instance sorts 8000 above 7FFF.
    run_one(vin, 1'b0, od, odesc, lat, extra
`ifdef SORT_INDEX_EN
            , oi
`endif
            );
    tests++;
    if (od !== pk8('{16'h0000, 16'h0001, 16'h7FFE, 16'h7FFF, 16'h8000, 16'h8001, 16'hFFFE, 16'hFFFF})) begin
      fails++; $display("FAIL unsigned_contrast got %h", od);
    end
  endtask

  task automatic test_log_n1();
    logic [15:0] od;
    int          lat;
    for (int dir = 0; dir < 2; dir++) begin
      t_in_data = {8'd3, 8'd5}; t_in_desc = dir[0]; t_in_valid = 1'b1; lat = -1; od = '0;
      for (int k = 1; k <= 10; k++) begin
        tick();
        t_in_valid = 1'b0;
        if (t_out_valid && lat < 0) begin lat = k; od = t_out_data; end
      end
      tests++; if (lat !== 1) begin fails++; $display("FAIL n2_dir%0d_latency got %0d want 1", dir, lat); end
      tests++; if (od !== (dir == 0 ? {8'd5, 8'd3} : {8'd3, 8'd5})) begin fails++; $display("FAIL n2_dir%0d_data got %h", dir, od); end
    end
    tests++; if (t_busy !== 1'b0 || t_in_ready !== 1'b1 || t_out_desc !== 1'b1) begin
      fails++; $display("FAIL n2_idle got busy %b ready %b desc %b want 0 1 1", t_busy, t_in_ready, t_out_desc);
    end
  endtask

  task automatic test_reset_midflight();
    logic [127:0] od;
    logic         odesc, extra;
    int           lat;
`ifdef SORT_INDEX_EN
    logic [23:0]  oi;
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = rand_vec(); in_desc = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy got %b want 0", busy); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_one({8{16'd4}}, 1'b0, od, odesc, lat, extra
`ifdef SORT_INDEX_EN
            , oi
`endif
            );
    tests++; if (lat !== 6) begin fails++; $display("FAIL mid_latency got %0d want 6", lat); end
    tests++; if (od !== {8{16'd4}}) begin fails++; $display("FAIL mid_data got %h want all 4", od); end
    tests++; if (extra !== 1'b0) begin fails++; $display("FAIL mid_stale_output got %b want 0", extra); end
`ifdef SORT_INDEX_EN
    tests++;
    if (oi !== {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}) begin
      fails++; $display("FAIL mid_index got %h want %h", oi, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    end
`endif
  endtask

  initial begin
    test_reset();
    test_asc_desc();
    test_back_to_back();
    test_backpressure();
    test_signed();
    test_log_n1();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
